mem_bus_arbiter: RTL and testbench

//  Shares one external synchronous data memory between NREQ simple processor cores.

---
 rtl/mem_bus_arbiter_pkg.sv | 15 +
 rtl/mem_bus_arbiter_if.sv | 33 +++
 rtl/mem_bus_arbiter_rr_picker.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 110 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and index widths.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Index width is sized for the largest supported core count so one
    // pointer type serves every NREQ in 2..8.
    localparam int MAX_NREQ = 8;
    localparam int IDXW     = $clog2(MAX_NREQ);

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Core-side request bus and memory-side port of the arbiter, bundled in one interface.
interface mem_bus_arbiter_if #(
    parameter int NREQ     = 2,
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 8
);
    // Handshake: a core raises req[i] with we/addr/wdata stable and holds it;
    // the arbiter answers with gnt[i] for the whole memory access, then a
    // one-cycle done[i] (with rdata valid for reads). Inputs are only sampled
    // while the arbiter is idle.
    logic [NREQ-1:0]          req;
    logic [NREQ-1:0]          req_we;
    logic [NREQ*ADDRSIZE-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]    req_wdata;
    logic [NREQ-1:0]          gnt;
    logic [NREQ-1:0]          done;
    logic [WIDTH-1:0]         rdata;
    logic                     mem_en;
    logic                     mem_we;
    logic [ADDRSIZE-1:0]      mem_addr;
    logic [WIDTH-1:0]         mem_wdata;
    logic [WIDTH-1:0]         mem_rdata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after (last+1) mod NREQ.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last,
    output logic            valid,
    output logic [IDXW-1:0] win
);

    // Scan offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (i == (int'(last) + k) % NREQ)) begin
                    valid = 1'b1;
                    win   = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between NREQ cores,
// one fixed-length access at a time.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int WIDTH      = 32,
    parameter int ADDRSIZE   = 8,
    parameter int ACC_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus,
    output state_t             dbg_state
);

    localparam int CNTW = $clog2(ACC_CYCLES + 1);

    state_t              state;
    logic [CNTW-1:0]     cnt;
    logic [IDXW-1:0]     last;
    logic [IDXW-1:0]     w_q;
    logic                pick_valid;
    logic [IDXW-1:0]     pick_win;
    logic                sel_we;
    logic [ADDRSIZE-1:0] sel_addr;
    logic [WIDTH-1:0]    sel_wdata;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (bus.req),
        .last  (last),
        .valid (pick_valid),
        .win   (pick_win)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_win == IDXW'(i)) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i*ADDRSIZE +: ADDRSIZE];
                sel_wdata = bus.req_wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign dbg_state = state;

    // last resets to NREQ-1 so the first scan starts at core 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            last          <= IDXW'(NREQ - 1);
            w_q           <= '0;
            bus.gnt       <= '0;
            bus.done      <= '0;
            bus.rdata     <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= '0;
                    if (pick_valid) begin
                        w_q           <= pick_win;
                        bus.gnt       <= NREQ'(1) << pick_win;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= sel_we;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        cnt           <= '0;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNTW'(ACC_CYCLES - 1)) begin
                        // Memory read data has been valid since the first access cycle.
                        if (!bus.mem_we) begin
                            bus.rdata <= bus.mem_rdata;
                        end
                        bus.done   <= bus.gnt;
                        bus.gnt    <= '0;
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= '0;
                    last     <= w_q;
                    state    <= IDLE;
                end
                default: begin
                    bus.gnt    <= '0;
                    bus.done   <= '0;
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table on a 2-core instance plus
// multi-cycle sequences, and a 4-core/3-cycle instance for the wider case.
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int ACC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.NREQ(2), .WIDTH(32), .ADDRSIZE(8)) bus1 ();
    mem_bus_arbiter_if #(.NREQ(4), .WIDTH(32), .ADDRSIZE(8)) bus2 ();
    state_t st1, st2;

    mem_bus_arbiter #(.NREQ(2), .WIDTH(32), .ADDRSIZE(8), .ACC_CYCLES(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state(st1)
    );

    mem_bus_arbiter #(.NREQ(4), .WIDTH(32), .ADDRSIZE(8), .ACC_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave), .dbg_state(st2)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem1 [256];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= '0;
            mem1[8'h10] <= 32'hDEADBEEF;
            mem1[8'h30] <= 32'h30303030;
            mem1[8'h40] <= 32'h40404040;
            mem1[8'h50] <= 32'h50505050;
        end else if (bus1.mem_en) begin
            if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
            else             bus1.mem_rdata      <= mem1[bus1.mem_addr];
        end
    end

    always @(posedge clk) begin
        if (bus2.mem_en && !bus2.mem_we) bus2.mem_rdata <= {24'h5A5A5A, bus2.mem_addr};
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("gnt_onehot0", 64'($onehot0(bus1.gnt)), 64'd1);
            chk("done_onehot0", 64'($onehot0(bus1.done)), 64'd1);
            chk("done_gnt_excl", 64'(bus1.done & bus1.gnt), 64'd0);
            if (bus1.done != 2'b00) begin
                if (exp_q.size() == 0) chk("done_unexpected", 64'(bus1.done), 64'd0);
                else                   chk("done_order", 64'(bus1.done), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  addr0;
        logic [7:0]  addr1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        int          win;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    // Runs one access from IDLE; called at a negedge, returns at a negedge in IDLE.
    task automatic run_vec(input vec_t v, input int n);
        logic [1:0]  e_gnt;
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_wd;
        e_gnt  = (v.win == 0) ? 2'b01 : 2'b10;
        e_we   = v.we[v.win];
        e_addr = (v.win == 0) ? v.addr0 : v.addr1;
        e_wd   = (v.win == 0) ? v.wd0 : v.wd1;
        bus1.req       = v.req;
        bus1.req_we    = v.we;
        bus1.req_addr  = {v.addr1, v.addr0};
        bus1.req_wdata = {v.wd1, v.wd0};
        exp_q.push_back(e_gnt);
        for (int c = 1; c <= ACC; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d_c%0d_gnt", n, c), 64'(bus1.gnt), 64'(e_gnt));
            chk($sformatf("v%0d_c%0d_mem_en", n, c), 64'(bus1.mem_en), 64'd1);
            chk($sformatf("v%0d_c%0d_mem_we", n, c), 64'(bus1.mem_we), 64'(e_we));
            chk($sformatf("v%0d_c%0d_mem_addr", n, c), 64'(bus1.mem_addr), 64'(e_addr));
            if (e_we) chk($sformatf("v%0d_c%0d_mem_wdata", n, c), 64'(bus1.mem_wdata), 64'(e_wd));
            chk($sformatf("v%0d_c%0d_done", n, c), 64'(bus1.done), 64'd0);
        end
        @(negedge clk);
        chk($sformatf("v%0d_done", n), 64'(bus1.done), 64'(e_gnt));
        chk($sformatf("v%0d_gnt_off", n), 64'(bus1.gnt), 64'd0);
        chk($sformatf("v%0d_mem_en_off", n), 64'(bus1.mem_en), 64'd0);
        chk($sformatf("v%0d_mem_we_off", n), 64'(bus1.mem_we), 64'd0);
        chk($sformatf("v%0d_rdata", n), 64'(bus1.rdata), 64'(v.exp_rdata));
        bus1.req = 2'b00;
        @(negedge clk);
        chk($sformatf("v%0d_idle", n), 64'(st1), 64'(IDLE));
        chk($sformatf("v%0d_done_low", n), 64'(bus1.done), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          ngnt;
        int          ndone;
        int          gcyc[4];
        logic [1:0]  gval[4];
        logic [1:0]  prev_gnt;
        logic [1:0]  order[4];
        int          en_cnt;
        int          done_cyc;
        logic [3:0]  done_val;
        logic [31:0] rd_exp;

        bus1.req = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus2.req = '0; bus2.req_we = '0; bus2.req_addr = '0; bus2.req_wdata = '0;

        vecs[0] = '{2'b01, 2'b00, 8'h10, 8'h00, 32'h0, 32'h0, 0, 32'hDEADBEEF};
        vecs[1] = '{2'b10, 2'b10, 8'h00, 8'h20, 32'h0, 32'h12345678, 1, 32'hDEADBEEF};
        vecs[2] = '{2'b01, 2'b00, 8'h20, 8'h00, 32'h0, 32'h0, 0, 32'h12345678};
        vecs[3] = '{2'b11, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 1, 32'h40404040};
        vecs[4] = '{2'b11, 2'b00, 8'h30, 8'h40, 32'h0, 32'h0, 0, 32'h30303030};
        vecs[5] = '{2'b11, 2'b11, 8'h50, 8'h60, 32'h0BAD0BAD, 32'h60000006, 1, 32'h30303030};
        vecs[6] = '{2'b10, 2'b00, 8'h00, 8'h60, 32'h0, 32'h0, 1, 32'h60000006};
        vecs[7] = '{2'b10, 2'b00, 8'h00, 8'h50, 32'h0, 32'h0, 1, 32'h50505050};
        vecs[8] = '{2'b01, 2'b01, 8'hFF, 8'h00, 32'hCAFEF00D, 32'h0, 0, 32'h50505050};
        vecs[9] = '{2'b01, 2'b00, 8'hFF, 8'h00, 32'h0, 32'h0, 0, 32'hCAFEF00D};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(bus1.gnt), 64'd0);
        chk("rst_done", 64'(bus1.done), 64'd0);
        chk("rst_rdata", 64'(bus1.rdata), 64'd0);
        chk("rst_mem_en", 64'(bus1.mem_en), 64'd0);
        chk("rst_mem_we", 64'(bus1.mem_we), 64'd0);
        chk("rst_mem_addr", 64'(bus1.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(bus1.mem_wdata), 64'd0);
        chk("rst_state", 64'(st1), 64'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 10; n++) run_vec(vecs[n], n);

        // Contention after a fresh reset: grants 0,1,0,1 with one idle cycle between
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus1.req = 2'b11; bus1.req_we = 2'b00; bus1.req_addr = {8'h40, 8'h10};
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
        for (int i = 0; i < 4; i++) exp_q.push_back(order[i]);
        ngnt = 0; ndone = 0; prev_gnt = 2'b00;
        for (int cyc = 0; cyc < 40 && ndone < 4; cyc++) begin
            @(negedge clk);
            if (bus1.gnt != 2'b00 && prev_gnt == 2'b00 && ngnt < 4) begin
                gcyc[ngnt] = cyc; gval[ngnt] = bus1.gnt; ngnt++;
            end
            prev_gnt = bus1.gnt;
            if (bus1.done != 2'b00) begin
                rd_exp = (bus1.done == 2'b01) ? 32'hDEADBEEF : 32'h40404040;
                chk($sformatf("cont_rdata%0d", ndone), 64'(bus1.rdata), 64'(rd_exp));
                ndone++;
                if (ndone == 4) bus1.req = 2'b00;
            end
        end
        chk("cont_ndone", 64'(ndone), 64'd4);
        chk("cont_ngnt", 64'(ngnt), 64'd4);
        for (int i = 0; i < 4; i++) if (i < ngnt) chk($sformatf("cont_gnt%0d", i), 64'(gval[i]), 64'(order[i]));
        for (int i = 0; i < 3; i++) if (i + 1 < ngnt) chk($sformatf("cont_gap%0d", i), 64'(gcyc[i+1] - gcyc[i]), 64'(ACC + 2));
        repeat (2) @(negedge clk);
        chk("cont_end_gnt", 64'(bus1.gnt), 64'd0);
        chk("cont_end_state", 64'(st1), 64'(IDLE));

        // Request dropped in the second access cycle still completes
        bus1.req = 2'b01; bus1.req_we = 2'b00; bus1.req_addr = {8'h00, 8'h10};
        exp_q.push_back(2'b01);
        @(negedge clk);
        chk("drop_gnt", 64'(bus1.gnt), 64'd1);
        @(negedge clk);
        bus1.req = 2'b00;
        @(negedge clk);
        chk("drop_done", 64'(bus1.done), 64'd1);
        chk("drop_rdata", 64'(bus1.rdata), 64'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drop_no_regrant%0d", i), 64'(bus1.gnt), 64'd0);
        end
        chk("drop_state", 64'(st1), 64'(IDLE));

        // Reset mid-access: core 1 would win now, reset must hand priority back to core 0
        bus1.req = 2'b11; bus1.req_we = 2'b00; bus1.req_addr = {8'h40, 8'h10};
        @(negedge clk);
        chk("mrst_pre_gnt", 64'(bus1.gnt), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_gnt", 64'(bus1.gnt), 64'd0);
        chk("mrst_done", 64'(bus1.done), 64'd0);
        chk("mrst_mem_en", 64'(bus1.mem_en), 64'd0);
        chk("mrst_mem_we", 64'(bus1.mem_we), 64'd0);
        chk("mrst_mem_addr", 64'(bus1.mem_addr), 64'd0);
        chk("mrst_rdata", 64'(bus1.rdata), 64'd0);
        chk("mrst_state", 64'(st1), 64'(IDLE));
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_first_gnt", 64'(bus1.gnt), 64'd1);
        exp_q.push_back(2'b01);
        bus1.req = 2'b00;
        for (int i = 0; i < 10 && bus1.done == 2'b00; i++) @(negedge clk);
        chk("mrst_done_core0", 64'(bus1.done), 64'd1);
        chk("mrst_done_rdata", 64'(bus1.rdata), 64'hDEADBEEF);
        repeat (2) @(negedge clk);

        // Four cores, three-cycle access: make core 1 the last served, then req=1010
        bus2.req = 4'b0010; bus2.req_we = 4'b0000; bus2.req_addr = {8'h00, 8'h00, 8'h11, 8'h00};
        for (int i = 0; i < 12 && bus2.done == 4'b0000; i++) @(negedge clk);
        chk("n4_pre_done", 64'(bus2.done), 64'h2);
        chk("n4_pre_rdata", 64'(bus2.rdata), 64'h5A5A5A11);
        bus2.req = 4'b0000;
        @(negedge clk);
        bus2.req = 4'b1010; bus2.req_addr = {8'h33, 8'h00, 8'h22, 8'h00};
        en_cnt = 0; done_cyc = 0; done_val = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("n4_gnt", 64'(bus2.gnt), 64'h8);
                chk("n4_mem_addr", 64'(bus2.mem_addr), 64'h33);
                bus2.req = 4'b0000;
            end
            if (bus2.mem_en) en_cnt++;
            if (bus2.done != 4'b0000) begin done_cyc = i; done_val = bus2.done; end
        end
        chk("n4_mem_en_cycles", 64'(en_cnt), 64'd3);
        chk("n4_done_cycle", 64'(done_cyc), 64'd4);
        chk("n4_done_val", 64'(done_val), 64'h8);
        chk("n4_rdata", 64'(bus2.rdata), 64'h5A5A5A33);
        chk("n4_state", 64'(st2), 64'(IDLE));

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
